adc_uart_streamer: RTL and testbench

Periodic multi-channel ADC sampler that serialises each frame of conversions as ASCII text over the UART transmitter. It sits between the ADC SPI receiver (request/busy/data-valid handshake) and the UART transmitter (data-valid/ack/done handshake) and replaces ad-hoc per-design counter-based streaming logic. Channel count, sample width, frame period and output radix are parametrised or selectable at runtime. It flags frames that are dropped because the previous frame is still being sent.

---
 rtl/adc_uart_pkg.sv | 41 ++++
 rtl/adc_uart_streamer_period_tick_gen.sv | 32 +++
 rtl/adc_uart_streamer.sv | 212 +++++++++++++++++++++
 tb/tb_adc_uart_streamer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_uart_pkg.sv
// Shared definitions for the ADC-to-UART text streamer: ASCII constants,
// FSM state and frame-phase enums, and a nibble-to-hex-character helper.
package adc_uart_pkg;

    localparam logic [7:0] COLON   = 8'h3A;
    localparam logic [7:0] COMMA   = 8'h2C;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ZERO    = 8'h30;
    localparam logic [7:0] A_UPPER = 8'h41;

    // Main controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CONV,
        ST_LOAD,
        ST_ACK,
        ST_DONE
    } state_e;

    // Which character of the frame text is being sent.
    typedef enum logic [2:0] {
        PH_CHAN,
        PH_COLON,
        PH_DIGIT,
        PH_COMMA,
        PH_CR,
        PH_LF
    } phase_e;

    // Uppercase ASCII hex digit for a 4-bit value.
    function automatic logic [7:0] nib2hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ZERO + {4'h0, nib};
        end else begin
            return A_UPPER + {4'h0, nib} - 8'd10;
        end
    endfunction

endpackage

// File: rtl/adc_uart_streamer_period_tick_gen.sv
// Free-running period counter producing a one-cycle tick at each wrap.
module period_tick_gen #(
    parameter int PERIOD_CYCLES = 50000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap to zero after the last cycle of the period.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Counter register; starts at zero out of reset and never stops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/adc_uart_streamer.sv
// Periodic multi-channel ADC sampler that sends each frame of conversions
// as ASCII text ("c:digits,...CRLF") through a UART transmitter handshake.
module adc_uart_streamer
    import adc_uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 12,
    parameter int NUM_CHANNELS  = 4,
    parameter int PERIOD_CYCLES = 50000000,
    parameter int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_hex_mode,
    output logic                  o_adc_request,
    output logic [CH_W-1:0]       o_adc_channel,
    input  logic                  i_adc_busy,
    input  logic                  i_adc_dv,
    input  logic [DATA_WIDTH-1:0] i_adc_data,
    output logic [7:0]            o_tx_byte,
    output logic                  o_tx_dv,
    input  logic                  i_tx_ack,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic [15:0]           o_frame_count
);

    // Hex digits cover the sample zero-padded up to a whole nibble.
    localparam int HEX_DIGITS = (DATA_WIDTH + 3) / 4;
    localparam int HEX_W      = 4 * HEX_DIGITS;
    localparam logic [CH_W-1:0] LAST_CH      = CH_W'(NUM_CHANNELS - 1);
    localparam logic [4:0]      LAST_BIN_DIG = 5'(DATA_WIDTH - 1);
    localparam logic [4:0]      LAST_HEX_DIG = 5'(HEX_DIGITS - 1);

    logic tick;

    period_tick_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_tick (tick)
    );

    state_e          state_q,     state_d;
    phase_e          phase_q,     phase_d;
    logic [CH_W-1:0] channel_q,   channel_d;
    logic            hex_q,       hex_d;
    logic [HEX_W-1:0] sreg_q,     sreg_d;
    logic [4:0]      digit_q,     digit_d;
    logic [7:0]      tx_byte_q,   tx_byte_d;
    logic            tx_dv_q,     tx_dv_d;
    logic            done_pend_q, done_pend_d;
    logic            overrun_q,   overrun_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    logic       busy;
    logic       last_digit;
    logic [7:0] digit_char;
    logic [7:0] next_char;

    assign busy = (state_q != ST_IDLE);

    // Character selection for the current frame position.
    always_comb begin
        last_digit = hex_q ? (digit_q == LAST_HEX_DIG) : (digit_q == LAST_BIN_DIG);
        if (hex_q) begin
            digit_char = nib2hex(sreg_q[HEX_W-1 -: 4]);
        end else begin
            digit_char = sreg_q[DATA_WIDTH-1] ? (ZERO + 8'd1) : ZERO;
        end
        case (phase_q)
            PH_CHAN:  next_char = nib2hex(4'(channel_q));
            PH_COLON: next_char = COLON;
            PH_DIGIT: next_char = digit_char;
            PH_COMMA: next_char = COMMA;
            PH_CR:    next_char = CR;
            PH_LF:    next_char = LF;
            default:  next_char = 8'h00;
        endcase
    end

    // Frame controller: next state, handshake outputs and frame bookkeeping.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        channel_d   = channel_q;
        hex_d       = hex_q;
        sreg_d      = sreg_q;
        digit_d     = digit_q;
        tx_byte_d   = tx_byte_q;
        tx_dv_d     = tx_dv_q;
        done_pend_d = done_pend_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        // A tick during a frame is lost; remember that it happened.
        if (tick && busy) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick && i_enable) begin
                    state_d   = ST_REQ;
                    hex_d     = i_hex_mode;
                    channel_d = '0;
                    phase_d   = PH_CHAN;
                end
            end
            ST_REQ: begin
                if (i_adc_busy) begin
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (i_adc_dv) begin
                    sreg_d  = HEX_W'(i_adc_data);
                    digit_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_byte_d = next_char;
                tx_dv_d   = 1'b1;
                state_d   = ST_ACK;
            end
            ST_ACK: begin
                if (i_tx_ack) begin
                    tx_dv_d = 1'b0;
                    // A done arriving with the ack must not be lost.
                    done_pend_d = i_tx_done;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_tx_done || done_pend_q) begin
                    done_pend_d = 1'b0;
                    state_d     = ST_LOAD;
                    case (phase_q)
                        PH_CHAN:  phase_d = PH_COLON;
                        PH_COLON: begin
                            phase_d = PH_DIGIT;
                            digit_d = '0;
                        end
                        PH_DIGIT: begin
                            if (!last_digit) begin
                                digit_d = digit_q + 5'd1;
                                sreg_d  = hex_q ? (sreg_q << 4) : (sreg_q << 1);
                            end else if (channel_q != LAST_CH) begin
                                phase_d = PH_COMMA;
                            end else begin
                                phase_d = PH_CR;
                            end
                        end
                        PH_COMMA: begin
                            channel_d = channel_q + 1'b1;
                            phase_d   = PH_CHAN;
                            state_d   = ST_REQ;
                        end
                        PH_CR:    phase_d = PH_LF;
                        PH_LF: begin
                            state_d     = ST_IDLE;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_CHAN;
            channel_q   <= '0;
            hex_q       <= 1'b0;
            sreg_q      <= '0;
            digit_q     <= '0;
            tx_byte_q   <= 8'h00;
            tx_dv_q     <= 1'b0;
            done_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            channel_q   <= channel_d;
            hex_q       <= hex_d;
            sreg_q      <= sreg_d;
            digit_q     <= digit_d;
            tx_byte_q   <= tx_byte_d;
            tx_dv_q     <= tx_dv_d;
            done_pend_q <= done_pend_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_adc_request = (state_q == ST_REQ);
    assign o_adc_channel = channel_q;
    assign o_tx_byte     = tx_byte_q;
    assign o_tx_dv       = tx_dv_q;
    assign o_busy        = busy;
    assign o_overrun     = overrun_q;
    assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_adc_uart_streamer.sv
// Directed bench: ADC and UART handshake models, captured byte stream is
// compared against hand-written frame text.
module tb_adc_uart_streamer;

    localparam int PERIOD = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        hex_mode = 1'b0;
    logic        adc_busy = 1'b0;
    logic        adc_dv = 1'b0;
    logic [11:0] adc_data = 12'h000;
    logic        tx_ack = 1'b0;
    logic        tx_done = 1'b0;

    logic        adc_request;
    logic [0:0]  adc_channel;
    logic [7:0]  tx_byte;
    logic        tx_dv;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_count;

    adc_uart_streamer #(
        .DATA_WIDTH   (12),
        .NUM_CHANNELS (2),
        .PERIOD_CYCLES(PERIOD)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_hex_mode   (hex_mode),
        .o_adc_request(adc_request),
        .o_adc_channel(adc_channel),
        .i_adc_busy   (adc_busy),
        .i_adc_dv     (adc_dv),
        .i_adc_data   (adc_data),
        .o_tx_byte    (tx_byte),
        .o_tx_dv      (tx_dv),
        .i_tx_ack     (tx_ack),
        .i_tx_done    (tx_done),
        .o_busy       (busy),
        .o_overrun    (overrun),
        .o_frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] q[$];
    logic [11:0] samp [2];
    int         uart_delay = 2;
    bit         together = 1'b0;
    bit         lat_chk = 1'b0;
    int         dv_cyc = 0;
    int         done_cyc = 0;
    int         adc_st = 0;
    int         adc_cnt = 0;
    int         u_st = 0;
    int         u_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC receiver model: busy for a few cycles after a request, then a dv pulse.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            adc_st   = 0;
            adc_busy = 1'b0;
            adc_dv   = 1'b0;
        end else begin
            case (adc_st)
                0: if (adc_request) begin
                    adc_busy = 1'b1;
                    adc_cnt  = 3;
                    adc_st   = 1;
                end
                1: begin
                    adc_cnt--;
                    if (adc_cnt == 0) begin
                        adc_busy = 1'b0;
                        adc_dv   = 1'b1;
                        adc_data = samp[adc_channel];
                        dv_cyc   = cyc;
                        adc_st   = 2;
                    end
                end
                default: begin
                    adc_dv = 1'b0;
                    adc_st = 0;
                end
            endcase
        end
    end

    // UART transmitter model: ack a valid byte, done after uart_delay cycles
    // (or together with the ack when 'together' is set).
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            u_st    = 0;
            tx_ack  = 1'b0;
            tx_done = 1'b0;
        end else begin
            case (u_st)
                0: if (tx_dv) begin
                    if (lat_chk && q.size() == 0) check("dv_to_txdv_lat", cyc - dv_cyc, 2);
                    if (lat_chk && q.size() == 1) check("done_to_txdv_lat", cyc - done_cyc, 2);
                    q.push_back(tx_byte);
                    tx_ack = 1'b1;
                    if (together) tx_done = 1'b1;
                    u_st = 1;
                end
                1: begin
                    if (lat_chk && q.size() == 1) check("ack_to_txdv_low", {31'b0, tx_dv}, 0);
                    tx_ack  = 1'b0;
                    tx_done = 1'b0;
                    if (together) begin
                        u_st = 0;
                    end else begin
                        u_cnt = uart_delay;
                        u_st  = 2;
                    end
                end
                2: begin
                    u_cnt--;
                    if (u_cnt <= 0) begin
                        tx_done  = 1'b1;
                        done_cyc = cyc;
                        u_st     = 3;
                    end
                end
                default: begin
                    tx_done = 1'b0;
                    u_st    = 0;
                end
            endcase
        end
    end

    task automatic wait_busy(input logic level, input int max_cyc, input string tag);
        int n = 0;
        while (busy !== level && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (busy !== level) check(tag, {31'b0, busy}, {31'b0, level});
    endtask

    task automatic wait_bytes(input int cnt, input string tag);
        int n = 0;
        while (q.size() < cnt && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() < cnt) check(tag, q.size(), cnt);
    endtask

    task automatic start_frame(input logic hex);
        hex_mode = hex;
        enable   = 1'b1;
        wait_busy(1'b1, 2 * PERIOD + 10, "busy_rise_timeout");
        enable   = 1'b0;
    endtask

    task automatic finish_frame();
        wait_busy(1'b0, 4000, "busy_fall_timeout");
        repeat (4) @(negedge clk);
    endtask

    task automatic check_bytes(input string tag, input string exp);
        check({tag, "_len"}, q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), {24'b0, q[i]}, {24'b0, exp[i]});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'b0, adc_request}, 0);
        check({tag, "_chan"},  {31'b0, adc_channel}, 0);
        check({tag, "_byte"},  {24'b0, tx_byte}, 0);
        check({tag, "_txdv"},  {31'b0, tx_dv}, 0);
        check({tag, "_busy"},  {31'b0, busy}, 0);
        check({tag, "_ovr"},   {31'b0, overrun}, 0);
        check({tag, "_count"}, {16'b0, frame_count}, 0);
    endtask

    initial begin
        samp[0] = 12'hABC;
        samp[1] = 12'h005;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Hex frame with ideal UART; also handshake latencies on the first bytes.
        lat_chk = 1'b1;
        start_frame(1'b1);
        finish_frame();
        lat_chk = 1'b0;
        check_bytes("hex", "0:ABC,1:005\015\012");
        check("hex_count", {16'b0, frame_count}, 1);
        check("hex_overrun", {31'b0, overrun}, 0);
        $display("frame hex: %0d bytes, count %0d", q.size(), frame_count);

        // Binary frame; hex_mode flipped mid-frame must not affect it.
        samp[0] = 12'hAB3;
        samp[1] = 12'h005;
        q.delete();
        start_frame(1'b0);
        wait_bytes(3, "bin_bytes_timeout");
        hex_mode = 1'b1;
        finish_frame();
        check_bytes("bin", "0:101010110011,1:000000000101\015\012");
        check("bin_count", {16'b0, frame_count}, 2);
        $display("frame bin: %0d bytes, count %0d", q.size(), frame_count);
        repeat (2 * PERIOD + 20) @(negedge clk);
        check("no_new_frame_bytes", q.size(), 31);
        check("no_new_frame_count", {16'b0, frame_count}, 2);

        // Ack and done together on every byte.
        together = 1'b1;
        samp[0] = 12'h01F;
        samp[1] = 12'hFFF;
        q.delete();
        start_frame(1'b1);
        finish_frame();
        together = 1'b0;
        check_bytes("ackdone", "0:01F,1:FFF\015\012");
        check("ackdone_count", {16'b0, frame_count}, 3);
        $display("frame ackdone: %0d bytes, count %0d", q.size(), frame_count);

        // Reset after the 5th byte; next frame starts cleanly.
        samp[0] = 12'hABC;
        samp[1] = 12'h005;
        q.delete();
        start_frame(1'b1);
        wait_bytes(5, "rst_bytes_timeout");
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        start_frame(1'b1);
        finish_frame();
        check_bytes("afterrst", "0:ABC,1:005\015\012");
        check("afterrst_count", {16'b0, frame_count}, 1);
        $display("frame afterrst: %0d bytes, count %0d", q.size(), frame_count);

        // Slow UART: frame outlasts the period, tick is dropped and flagged.
        check("pre_overrun", {31'b0, overrun}, 0);
        uart_delay = 60;
        q.delete();
        hex_mode = 1'b1;
        enable   = 1'b1;
        wait_busy(1'b1, 2 * PERIOD + 10, "slow_busy_timeout");
        repeat (PERIOD + 50) @(negedge clk);
        enable = 1'b0;
        finish_frame();
        check("overrun_set", {31'b0, overrun}, 1);
        check_bytes("slow", "0:ABC,1:005\015\012");
        check("slow_count", {16'b0, frame_count}, 2);
        repeat (2 * PERIOD) @(negedge clk);
        check("slow_no_extra", q.size(), 13);
        check("overrun_sticky", {31'b0, overrun}, 1);
        $display("frame slow: %0d bytes, count %0d, overrun %0d", q.size(), frame_count, overrun);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
